// File: rtl/sysid_uptime_regs.sv
// System-ID slave: build ID, timestamp, capability word, scratch register and,
// when SYSID_UPTIME_EN is defined, a prescaled 64-bit uptime counter with tear-free snapshot.
module sysid_uptime_regs #(
  parameter logic [31:0] SYSTEM_ID  = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP  = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 3,
  parameter int          CLK_DIV    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  input  logic [3:0]            byteenable,
  output logic [31:0]           readdata,
  output logic                  readdatavalid
);

  localparam logic [ADDR_WIDTH-1:0] A_ID      = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_TSTAMP  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_CAPS    = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_SCRATCH = ADDR_WIDTH'(3);
  localparam logic [15:0]           DIV16     = 16'(CLK_DIV);
  localparam logic [7:0]            VERSION   = 8'h02;

`ifdef SYSID_UPTIME_EN
  localparam logic                  UPTIME_BUILT = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] A_UP_LO      = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_UP_HI      = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL       = ADDR_WIDTH'(7);
  localparam logic [15:0]           PRESC_TC     = 16'(CLK_DIV - 1);
`else
  localparam logic                  UPTIME_BUILT = 1'b0;
`endif

  localparam logic [31:0] CAPS_WORD = {VERSION, 7'd0, UPTIME_BUILT, DIV16};

  // A read that collides with a write is dropped entirely.
  logic        rd_ok;
  logic [31:0] scratch;
  logic [31:0] rd_mux;
  logic        rdv_q;

  assign rd_ok = read & ~write;

  always_ff @(posedge clock) begin
    if (reset) begin
      scratch <= 32'h0;
    end else if (write && address == A_SCRATCH) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) scratch[8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

`ifdef SYSID_UPTIME_EN
  logic [15:0] uptime_presc;
  logic [63:0] uptime_cnt;
  logic [31:0] hi_shadow;
  logic        freeze;
  logic        ctrl_wr;
  logic        clear;

  assign ctrl_wr = write && (address == A_CTRL) && byteenable[0];
  assign clear   = ctrl_wr && writedata[0];

  // CLEAR beats both FREEZE and the tick; FREEZE written alongside lands next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      uptime_presc <= 16'h0;
      uptime_cnt   <= 64'h0;
      freeze       <= 1'b0;
    end else begin
      if (ctrl_wr) freeze <= writedata[1];
      if (clear) begin
        uptime_presc <= 16'h0;
        uptime_cnt   <= 64'h0;
      end else if (!freeze) begin
        if (uptime_presc == PRESC_TC) begin
          uptime_presc <= 16'h0;
          uptime_cnt   <= uptime_cnt + 64'd1;
        end else begin
          uptime_presc <= uptime_presc + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi_shadow <= 32'h0;
    end else if (rd_ok && address == A_UP_LO) begin
      hi_shadow <= uptime_cnt[63:32];
    end
  end
`endif

  always_comb begin
    rd_mux = 32'h0;
    case (address)
      A_ID:      rd_mux = SYSTEM_ID;
      A_TSTAMP:  rd_mux = TIMESTAMP;
      A_CAPS:    rd_mux = CAPS_WORD;
      A_SCRATCH: rd_mux = scratch;
`ifdef SYSID_UPTIME_EN
      A_UP_LO:   rd_mux = uptime_cnt[31:0];
      A_UP_HI:   rd_mux = hi_shadow;
      A_CTRL:    rd_mux = {30'd0, freeze, 1'b0};
`endif
      default:   rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      readdata <= 32'h0;
      rdv_q    <= 1'b0;
    end else begin
      rdv_q <= rd_ok;
      if (rd_ok) readdata <= rd_mux;
    end
  end

  // Masking with reset kills a result already in flight when reset arrives.
  assign readdatavalid = rdv_q & ~reset;

endmodule

// File: tb/tb_sysid_uptime_regs.sv
// Scoreboard bench for sysid_uptime_regs; adapts to SYSID_UPTIME_EN being defined or not.
module tb_sysid_uptime_regs;

  localparam logic [31:0] SID = 32'h53A9_0187;
  localparam logic [31:0] TS  = 32'hA013_4E24;
  localparam int          AW  = 4;
  localparam int          DIV = 4;
`ifdef SYSID_UPTIME_EN
  localparam bit UP = 1'b1;
`else
  localparam bit UP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] address = '0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [31:0]   writedata = 32'h0;
  logic [3:0]    byteenable = 4'h0;
  logic [31:0]   readdata;
  logic          readdatavalid;

  always #5 clock = ~clock;

  sysid_uptime_regs #(
    .SYSTEM_ID (SID),
    .TIMESTAMP (TS),
    .ADDR_WIDTH(AW),
    .CLK_DIV   (DIV)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .readdata     (readdata),
    .readdatavalid(readdatavalid)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state; only the model process writes these.
  logic [31:0] exp_q[$];
  logic [31:0] m_scratch = 32'h0;
  logic [31:0] m_shadow  = 32'h0;
  logic [31:0] m_last    = 32'h0;
  logic        m_freeze  = 1'b0;
  logic [63:0] m_cnt     = 64'h0;
  int          m_presc   = 0;
  bit          preload_req = 1'b0;
  int          rd_idx = 0;

  function automatic logic [31:0] model_word(int a);
    case (a)
      0: return SID;
      1: return TS;
      2: return {8'h02, 7'd0, UP, 16'(DIV)};
      3: return m_scratch;
      4: return UP ? m_cnt[31:0] : 32'h0;
      5: return UP ? m_shadow : 32'h0;
      7: return UP ? {30'd0, m_freeze, 1'b0} : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clock) begin
    logic        clr;
    logic        nf;
    logic [31:0] e;
    if (preload_req) m_cnt = 64'h0000_0000_FFFF_FFFF;
    if (reset) begin
      m_scratch = 32'h0; m_shadow = 32'h0; m_last = 32'h0;
      m_freeze = 1'b0; m_cnt = 64'h0; m_presc = 0;
    end else begin
      clr = 1'b0;
      nf  = m_freeze;
      if (read && !write) begin
        e = model_word(int'(address));
        if (UP && int'(address) == 4) m_shadow = m_cnt[63:32];
        exp_q.push_back(e);
        m_last = e;
      end
      if (write) begin
        if (int'(address) == 3)
          for (int b = 0; b < 4; b++)
            if (byteenable[b]) m_scratch[8*b +: 8] = writedata[8*b +: 8];
        if (UP && int'(address) == 7 && byteenable[0]) begin
          clr = writedata[0];
          nf  = writedata[1];
        end
      end
      if (UP) begin
        if (clr) begin
          m_cnt = 64'h0; m_presc = 0;
        end else if (!m_freeze) begin
          m_presc++;
          if (m_presc == DIV) begin
            m_presc = 0;
            m_cnt   = m_cnt + 64'd1;
          end
        end
      end
      m_freeze = nf;
    end
  end

  // Monitor: a result is owed whenever the model queued one and reset is not masking it.
  always @(negedge clock) begin
    bit exp_v;
    exp_v = (exp_q.size() > rd_idx) && !reset;
    vectors++;
    if (readdatavalid !== exp_v) begin
      miscompares++;
      $display("FAIL readdatavalid: got %0b expected %0b at %0t", readdatavalid, exp_v, $time);
    end
    if (exp_v) begin
      vectors++;
      if (readdatavalid && readdata !== exp_q[rd_idx]) begin
        miscompares++;
        $display("FAIL readdata: got %08h expected %08h at %0t", readdata, exp_q[rd_idx], $time);
      end
      rd_idx++;
    end else if (!readdatavalid) begin
      vectors++;
      if (readdata !== m_last) begin
        miscompares++;
        $display("FAIL readdata_hold: got %08h expected %08h at %0t", readdata, m_last, $time);
      end
    end
    if (reset) rd_idx = exp_q.size();
  end

  task automatic cyc(input bit rd, input bit wr, input int a, input logic [31:0] wd,
                     input logic [3:0] be);
    @(posedge clock);
    #2;
    read = rd; write = wr; address = AW'(a); writedata = wd; byteenable = be;
    preload_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 32'h0, 4'h0);
  endtask

  initial begin
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 2, 0, 0);
    cyc(1, 0, 9, 0, 0);
    cyc(0, 1, 3, 32'hDEAD_BEEF, 4'hF);
    cyc(1, 0, 3, 0, 0);
    cyc(0, 1, 3, 32'h0000_1200, 4'b0010);
    cyc(1, 0, 3, 0, 0);
    idle(40);
    cyc(1, 0, 4, 0, 0);
    cyc(1, 0, 5, 0, 0);
    cyc(0, 1, 7, 32'h0000_0002, 4'h1);
    cyc(1, 0, 7, 0, 0);
    idle(100);
    cyc(1, 0, 4, 0, 0);
    cyc(0, 1, 7, 32'h0000_0001, 4'hE);
    cyc(1, 0, 7, 0, 0);
    cyc(0, 1, 7, 32'h0000_0001, 4'h1);
    cyc(1, 0, 4, 0, 0);
    idle(5);
    cyc(0, 1, 7, 32'h0000_0003, 4'h1);
    cyc(1, 0, 4, 0, 0);
    cyc(1, 0, 7, 0, 0);
    idle(10);
    cyc(1, 0, 4, 0, 0);
    cyc(0, 1, 4, 32'hFFFF_FFFF, 4'hF);
    cyc(0, 1, 5, 32'hFFFF_FFFF, 4'hF);
    cyc(0, 1, 7, 32'h0000_0000, 4'h1);
    cyc(1, 0, 4, 0, 0);
    cyc(1, 0, 5, 0, 0);
    idle(6);
`ifdef SYSID_UPTIME_EN
    for (int i = 0; i < 8 && m_presc != 0; i++) idle(1);
    force dut.uptime_cnt = 64'h0000_0000_FFFF_FFFF;
    preload_req = 1'b1;
    #1 release dut.uptime_cnt;
    for (int i = 0; i < 8 && m_presc != DIV - 1; i++) idle(1);
    cyc(1, 0, 4, 0, 0);
    cyc(1, 0, 5, 0, 0);
    cyc(1, 0, 4, 0, 0);
    cyc(1, 0, 5, 0, 0);
`endif
    cyc(1, 1, 3, 32'h1234_5678, 4'hF);
    cyc(1, 0, 3, 0, 0);
    cyc(1, 1, 4, 32'h0, 4'hF);
    idle(2);
    cyc(1, 0, 0, 0, 0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    cyc(1, 0, 1, 0, 0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    cyc(1, 0, 3, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      int r, a;
      logic [31:0] wd;
      r  = $urandom_range(0, 9);
      a  = $urandom_range(0, 15);
      wd = $urandom;
      if (a == 7 && $urandom_range(0, 7) != 0) wd[0] = 1'b0;
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        cyc(r < 5, 1'b0, a, wd, 4'(($urandom)));
        reset = 1'b0;
      end else if (r < 5) cyc(1, 0, a, wd, 4'(($urandom)));
      else if (r < 8)     cyc(0, 1, a, wd, 4'(($urandom)));
      else if (r == 8)    cyc(1, 1, a, wd, 4'(($urandom)));
      else                idle(1);
    end
    idle(4);
    vectors++;
    if (exp_q.size() != rd_idx) begin
      miscompares++;
      $display("FAIL drain: %0d reads never answered, expected 0", exp_q.size() - rd_idx);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sysid_uptime_regs.md
Name: sysid_uptime_regs

Overview:
- Parametrised system-ID slave for the Avalon-MM control bus; successor to the fixed two-word ID block.
- Returns build ID, build timestamp and a capability word.
- Adds a writable scratch register, a free-running 64-bit uptime counter with a prescaler and atomic 64-bit snapshot read, and a control register.
- Registered read with fixed latency 1; sits on the host CPU's peripheral bus next to the other system peripherals.

Parameters:
- SYSTEM_ID, 32'h00000000, value returned at word 0.
- TIMESTAMP, 32'h00000000, build timestamp returned at word 1.
- ADDR_WIDTH, 3, word-address width; minimum 3; words 8..2^ADDR_WIDTH-1 read 0.
- CLK_DIV, 1, clock cycles per uptime tick; range 1..65535.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous active-high reset.
- address  in  ADDR_WIDTH  word address.
- read  in  1  read strobe, one-cycle pulse per access.
- write  in  1  write strobe.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for write.
- readdata  out  32  read data, registered.
- readdatavalid  out  1  one-cycle pulse qualifying readdata.

Behaviour:
Interface:
- One clock, `clock`; reset is synchronous and active-high on `reset`.
- No waitrequest; every access is accepted in the cycle presented.

Register map (word address):
- 0 ID: read-only, SYSTEM_ID.
- 1 TIMESTAMP: read-only, TIMESTAMP.
- 2 CAPS: read-only.
  - [15:0] = CLK_DIV[15:0]
  - [16] = 1 if uptime compiled in
  - [23:17] = 0
  - [31:24] = 8'h02 (block version)
- 3 SCRATCH: read/write, per-byte via byteenable; reset 0.
- 4 UPTIME_LO: read returns counter[31:0]; same cycle latches counter[63:32] into HI_SHADOW.
- 5 UPTIME_HI: returns HI_SHADOW; reset 0.
- 6 reserved: reads 0, writes ignored.
- 7 CONTROL:
  - bit0 CLEAR: write-1 self-clearing pulse, reads 0.
  - bit1 FREEZE: read/write, reset 0.
  - Other bits read 0.
  - Written only when byteenable[0]=1.
- Writes to read-only or unmapped words are ignored.

Read timing:
- read=1 in cycle N → readdata valid and readdatavalid=1 in cycle N+1 only.
- readdata holds its last value when readdatavalid=0.
- Back-to-back reads are supported, one result per cycle.

Simultaneous read and write:
- The write is performed.
- The read is dropped: no readdatavalid, and no shadow latch.

Reset values: readdata=0, readdatavalid=0, SCRATCH=0, FREEZE=0, prescaler=0, counter=0, HI_SHADOW=0.

Uptime counter:
- Prescaler counts 0..CLK_DIV-1 each cycle.
- When the prescaler equals CLK_DIV-1 it returns to 0 and counter increments by 1.
- CLK_DIV=1 → counter increments every cycle.
- Counter wraps 64'hFFFFFFFF_FFFFFFFF → 0 silently.
- FREEZE=1: prescaler and counter hold; reads and snapshot still work.
- CLEAR write: prescaler and counter are 0 in the next cycle.
  - CLEAR has priority over the increment and over FREEZE.
  - A write with bit0=1 and bit1=1 clears and sets FREEZE in the same cycle.
- Snapshot: UPTIME_LO read in cycle N captures bits [63:32] of the counter value in cycle N, the same value whose low half is returned.
  - This gives a tear-free 64-bit read when the order is LO then HI.
- Reading UPTIME_HI without a prior LO read returns the stale shadow.

Reset mid-operation:
- All state returns to reset values next cycle.
- A read pending in the cycle reset is asserted produces no readdatavalid.

Optional Feature:
- Macro SYSID_UPTIME_EN.
- Defined: prescaler, 64-bit counter, HI_SHADOW and CONTROL implemented as above; CAPS[16]=1.
- Undefined:
  - No counter or prescaler logic is built.
  - Words 4, 5 and 7 read 0 and writes to them are ignored.
  - CAPS[16]=0.
  - ID, TIMESTAMP, CAPS and SCRATCH unchanged.

Test Plan:
- Reset, then reads of words 0, 1, 2 with SYSTEM_ID=32'h53A9_0187, TIMESTAMP=32'hA013_4E24, CLK_DIV=4 → readdatavalid one cycle after each read; data 53A90187, A0134E24, 0201_0004.
- Write SCRATCH 32'hDEADBEEF, then byteenable=4'b0010 write 32'h00001200 → read returns DEADBEEF, then DEAD12EF.
- CLK_DIV=4, release reset, wait 40 cycles, read UPTIME_LO → 10 (±1 with read offset checked exactly against the model); FREEZE=1, wait 100 cycles → value unchanged; CLEAR → next read 0.
- Preload counter to 64'h00000000_FFFFFFFF (CLK_DIV=1, force), read LO in the cycle before carry → LO=FFFFFFFF, subsequent HI read = 0 (not 1).
- Read and write asserted together to SCRATCH → SCRATCH updated, no readdatavalid; reset asserted the cycle after a read → readdatavalid stays 0.
- Build without SYSID_UPTIME_EN → words 4, 5, 7 read 0, CAPS[16]=0, writes to 7 have no effect.
